// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters with pipeline-aligned
// sync/de plus frame_start, tick and frame_count frame events.
module vga_timing_gen #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   PIPE_DELAY  = 1,
  parameter int   TICK_FRAMES = 30
) (
  input  logic        pxl_clk,
  input  logic        rst_n,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        tick,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HL     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VL     = 10'(V_TOTAL - 1);
  localparam logic [15:0] TF_M1 = 16'(TICK_FRAMES - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_DELAY out of 0..7");
  end
  if (TICK_FRAMES < 1 || TICK_FRAMES > 65535) begin : g_bad_tick
    $error("vga_timing_gen: TICK_FRAMES out of 1..65535");
  end

  logic [9:0]  x_nx;
  logic [9:0]  y_nx;
  logic        act_nx;
  logic        hs_nx;
  logic        vs_nx;
  logic        home_nx;
  logic        blank_nx;
  logic [15:0] tdiv;

  // Stage 0 holds the undelayed decode; stage PIPE_DELAY feeds the pins.
  logic [PIPE_DELAY:0] hs_p;
  logic [PIPE_DELAY:0] vs_p;
  logic [PIPE_DELAY:0] de_p;

  // Next raster position and the decodes describing it.
  always_comb begin
    x_nx = x + 10'd1;
    y_nx = y;
    if (x == HL) begin
      x_nx = '0;
      y_nx = (y == VL) ? '0 : y + 10'd1;
    end
    act_nx   = (x_nx < HA) && (y_nx < VA);
    hs_nx    = (x_nx >= HS_ON) && (x_nx < HS_OFF)
               ? SYNC_POL : ~SYNC_POL;
    vs_nx    = (y_nx >= VS_ON) && (y_nx < VS_OFF)
               ? SYNC_POL : ~SYNC_POL;
    home_nx  = (x_nx == '0) && (y_nx == '0);
    blank_nx = (x_nx == HA) && (y_nx == VA);
  end

  // Raster counters and frame events.
  always_ff @(posedge pxl_clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= HL;
      y           <= VL;
      frame_start <= 1'b0;
      frame_count <= 16'hFFFF;
      tick        <= 1'b0;
      tdiv        <= '0;
    end else begin
      x           <= x_nx;
      y           <= y_nx;
      frame_start <= home_nx;
      tick        <= blank_nx && (tdiv == TF_M1);
      if (home_nx) begin
        frame_count <= frame_count + 16'd1;
      end
      if (blank_nx) begin
        tdiv <= (tdiv == TF_M1) ? '0 : tdiv + 16'd1;
      end
    end
  end

  // Sync/de delay line; reset fills it with inactive levels.
  always_ff @(posedge pxl_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p <= {(PIPE_DELAY + 1){~SYNC_POL}};
      vs_p <= {(PIPE_DELAY + 1){~SYNC_POL}};
      de_p <= '0;
    end else begin
      hs_p[0] <= hs_nx;
      vs_p[0] <= vs_nx;
      de_p[0] <= act_nx;
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
        de_p[i] <= de_p[i-1];
      end
    end
  end

  assign active = de_p[0];
  assign de     = de_p[PIPE_DELAY];
  assign hsync  = hs_p[PIPE_DELAY];
  assign vsync  = vs_p[PIPE_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench, three configurations on a shared
// clock/reset, expected outputs queued per cycle and checked at negedge.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        active;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        fs;
    logic        tick;
    logic [15:0] fc;
  } out_t;

  typedef struct {
    int         t;
    logic [9:0] x;
    logic [9:0] y;
    logic       a;
    logic       hs;
    logic       de;
  } hv_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0]  x0, y0, x1, y1, x2, y2;
  logic        a0, hs0, vs0, de0, fs0, tk0;
  logic        a1, hs1, vs1, de1, fs1, tk1;
  logic        a2, hs2, vs2, de2, fs2, tk2;
  logic [15:0] fc0, fc1, fc2;

  vga_timing_gen u_d0 (
    .pxl_clk(clk), .rst_n(rst_n), .x(x0), .y(y0), .active(a0),
    .hsync(hs0), .vsync(vs0), .de(de0), .frame_start(fs0),
    .tick(tk0), .frame_count(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .PIPE_DELAY(3), .TICK_FRAMES(3)
  ) u_d1 (
    .pxl_clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .active(a1),
    .hsync(hs1), .vsync(vs1), .de(de1), .frame_start(fs1),
    .tick(tk1), .frame_count(fc1)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .PIPE_DELAY(0), .TICK_FRAMES(1)
  ) u_d2 (
    .pxl_clk(clk), .rst_n(rst_n), .x(x2), .y(y2), .active(a2),
    .hsync(hs2), .vsync(vs2), .de(de2), .frame_start(fs2),
    .tick(tk2), .frame_count(fc2)
  );

  int checks = 0;
  int errors = 0;
  int t;
  bit p1 = 1'b0;
  int ntk1 = 0, ntk2 = 0, nfs1 = 0, nfs0 = 0;

  out_t q0[$];
  out_t q1[$];
  out_t q2[$];
  int   tq[$];
  hv_t  hv[12];
  int   hv_i = 0;

  // Cycle t since reset release (t<0: in reset).
  function automatic out_t model(
    input int ha, hf, hs, hb, va, vf, vs, vb, pd, tf,
    input bit pol, input int tt);
    int ht, vt, px, py, f, td, dx, dy;
    out_t e;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (tt < 0) begin
      e.x = 10'(ht - 1); e.y = 10'(vt - 1);
      e.active = 0; e.de = 0; e.fs = 0; e.tick = 0;
      e.hsync = !pol; e.vsync = !pol; e.fc = 16'hFFFF;
      return e;
    end
    px = tt % ht;
    py = (tt / ht) % vt;
    f  = tt / (ht * vt);
    e.x = 10'(px);
    e.y = 10'(py);
    e.active = (px < ha) && (py < va);
    e.fs = (px == 0) && (py == 0);
    e.fc = 16'(f);
    e.tick = (px == ha) && (py == va) && ((f + 1) % tf == 0);
    e.de = 0; e.hsync = !pol; e.vsync = !pol;
    td = tt - pd;
    if (td >= 0) begin
      dx = td % ht;
      dy = (td / ht) % vt;
      e.de = (dx < ha) && (dy < va);
      if (dx >= ha + hf && dx < ha + hf + hs) e.hsync = pol;
      if (dy >= va + vf && dy < va + vf + vs) e.vsync = pol;
    end
    return e;
  endfunction

  function automatic out_t pack(
    input logic [9:0] x, y, input logic a, hs, vs, d, fs, tk,
    input logic [15:0] fc);
    out_t o;
    o.x = x; o.y = y; o.active = a; o.hsync = hs; o.vsync = vs;
    o.de = d; o.fs = fs; o.tick = tk; o.fc = fc;
    return o;
  endfunction

  task automatic chk(input string nm, input int tt,
                     input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h exp=%h", nm, tt, got, exp);
    end
  endtask

  task automatic push(input int tt);
    q0.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 1, 30, 1'b0, tt));
    q1.push_back(model(8, 2, 3, 2, 4, 1, 2, 1, 3, 3, 1'b0, tt));
    q2.push_back(model(8, 2, 3, 2, 4, 1, 2, 1, 0, 1, 1'b1, tt));
    tq.push_back(tt);
  endtask

  task automatic step();
    @(posedge clk);
    t++;
    #1 push(t);
  endtask

  // Monitor: pop and compare whatever the driver queued this cycle.
  initial begin
    int   tt;
    out_t e0, e1, e2;
    forever begin
      @(negedge clk);
      while (tq.size() > 0) begin
        tt = tq.pop_front();
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        chk("d0_out", tt,
            64'(pack(x0, y0, a0, hs0, vs0, de0, fs0, tk0, fc0)), 64'(e0));
        chk("d1_out", tt,
            64'(pack(x1, y1, a1, hs1, vs1, de1, fs1, tk1, fc1)), 64'(e1));
        chk("d2_out", tt,
            64'(pack(x2, y2, a2, hs2, vs2, de2, fs2, tk2, fc2)), 64'(e2));
        if (hv_i < 12 && tt >= 0 && hv[hv_i].t == tt) begin
          chk("d0_hand", tt, 64'({x0, y0, a0, hs0, de0}),
              64'({hv[hv_i].x, hv[hv_i].y, hv[hv_i].a,
                   hv[hv_i].hs, hv[hv_i].de}));
          hv_i++;
        end
        if (p1) begin
          ntk1 += int'(tk1);
          ntk2 += int'(tk2);
          nfs1 += int'(fs1);
          nfs0 += int'(fs0);
        end
      end
    end
  end

  // Driver: reset, long run, async mid-frame reset, short rerun.
  initial begin
    hv[0]  = '{0,   10'd0,   10'd0, 1'b1, 1'b1, 1'b0};
    hv[1]  = '{1,   10'd1,   10'd0, 1'b1, 1'b1, 1'b1};
    hv[2]  = '{639, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
    hv[3]  = '{640, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1};
    hv[4]  = '{641, 10'd641, 10'd0, 1'b0, 1'b1, 1'b0};
    hv[5]  = '{656, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0};
    hv[6]  = '{657, 10'd657, 10'd0, 1'b0, 1'b0, 1'b0};
    hv[7]  = '{752, 10'd752, 10'd0, 1'b0, 1'b0, 1'b0};
    hv[8]  = '{753, 10'd753, 10'd0, 1'b0, 1'b1, 1'b0};
    hv[9]  = '{799, 10'd799, 10'd0, 1'b0, 1'b1, 1'b0};
    hv[10] = '{800, 10'd0,   10'd1, 1'b1, 1'b1, 1'b0};
    hv[11] = '{801, 10'd1,   10'd1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    t = -1;
    repeat (3) begin
      @(posedge clk);
      #1 push(-1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    p1 = 1'b1;
    repeat (1700) step();
    @(negedge clk);
    #1;
    p1 = 1'b0;
    chk("d1_tick_cnt", t, 64'(ntk1), 64'd4);
    chk("d2_tick_cnt", t, 64'(ntk2), 64'd14);
    chk("d1_fs_cnt", t, 64'(nfs1), 64'd15);
    chk("d0_fs_cnt", t, 64'(nfs0), 64'd1);

    // Land the small configs at (5,3), then reset between edges.
    while ((t + 1) % 120 != 50) step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    t = -1;
    #1 push(-1);
    repeat (2) begin
      @(posedge clk);
      #1 push(-1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (400) step();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 0, 64'(tq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
